// File: rtl/prog_clk_gen.sv
// rtl/prog_clk_gen.sv - programmable glitch-free test clock divider; optional glitch one-shot under GLITCH_INJECT_EN
module prog_clk_gen #(
  parameter int WIDTH          = 8,
  parameter int DEFAULT_PERIOD = 150
) (
  input  logic             main_clock,
  input  logic             main_reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] period_in,
  input  logic             load_valid,
`ifdef GLITCH_INJECT_EN
  input  logic             glitch_req,
`endif
  output logic             load_ack,
  output logic             gen_clk,
  output logic             cycle_tick,
  output logic [WIDTH-1:0] period_cur,
  output logic             pending,
  output logic             running
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE          = WIDTH'(1);
  localparam logic [WIDTH-1:0] MIN_PERIOD   = WIDTH'(2);
  localparam logic [WIDTH-1:0] RESET_PERIOD = WIDTH'(DEFAULT_PERIOD);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q;
  logic [WIDTH-1:0] period_eff;
  logic [WIDTH-1:0] high_len;
  logic             gen_d, tick_d;
  logic             wrap, capture, apply;
  logic             glitch_start, glitch_active;

  // The glitch period overrides period_cur for exactly one period; odd periods give the extra cycle to the high phase
  assign period_eff = glitch_active ? MIN_PERIOD : period_cur;
  assign high_len   = period_eff - (period_eff >> 1);
  assign wrap       = (state_q != IDLE) && (cnt_q == period_eff - ONE);

  // A new value is only captured into an empty hold register; it is applied at a boundary (or at once when idle),
  // except when the boundary launches a glitch period, in which case it waits for the glitch period to end
  assign capture = load_valid && !pending;
  assign apply   = pending && ((state_q == IDLE) || (wrap && !glitch_start));
  assign running = (state_q != IDLE);

  // State register
  always_ff @(posedge main_clock or negedge main_reset) begin
    if (!main_reset) state_q <= IDLE;
    else             state_q <= state_d;
  end

  // Next-state: DRAIN finishes the current period and only leaves to IDLE on its wrap
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (!enable) state_d = DRAIN;
      DRAIN: begin
        if (enable)    state_d = RUN;
        else if (wrap) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode: next counter, clock level and tick, all registered below so no input reaches an output directly
  always_comb begin
    cnt_d  = '0;
    gen_d  = 1'b0;
    tick_d = 1'b0;
    if (state_d != IDLE) begin
      if ((state_q == IDLE) || wrap) begin
        gen_d  = 1'b1;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + ONE;
        gen_d = ((cnt_q + ONE) < high_len);
      end
    end
  end

  // Counter, waveform and load handshake registers
  always_ff @(posedge main_clock or negedge main_reset) begin
    if (!main_reset) begin
      cnt_q      <= '0;
      gen_clk    <= 1'b0;
      cycle_tick <= 1'b0;
      load_ack   <= 1'b0;
      pending    <= 1'b0;
      hold_q     <= RESET_PERIOD;
      period_cur <= RESET_PERIOD;
    end else begin
      cnt_q      <= cnt_d;
      gen_clk    <= gen_d;
      cycle_tick <= tick_d;
      load_ack   <= capture;
      if (apply) begin
        period_cur <= hold_q;
        pending    <= 1'b0;
      end
      if (capture) begin
        hold_q  <= (period_in < MIN_PERIOD) ? MIN_PERIOD : period_in;
        pending <= 1'b1;
      end
    end
  end

`ifdef GLITCH_INJECT_EN
  logic glitch_armed;

  assign glitch_start = wrap && glitch_armed && (state_d != IDLE);

  // One-shot: a request in RUN arms it, the next wrap launches a single 2-cycle period
  always_ff @(posedge main_clock or negedge main_reset) begin
    if (!main_reset) begin
      glitch_armed  <= 1'b0;
      glitch_active <= 1'b0;
    end else if (state_d == IDLE) begin
      glitch_armed  <= 1'b0;
      glitch_active <= 1'b0;
    end else begin
      glitch_armed <= (glitch_armed && !glitch_start) || (glitch_req && (state_q == RUN));
      if (wrap) glitch_active <= glitch_start;
    end
  end
`else
  assign glitch_start  = 1'b0;
  assign glitch_active = 1'b0;
`endif

endmodule

// File: tb/tb_prog_clk_gen.sv
// tb/tb_prog_clk_gen.sv - randomized self-checking bench for prog_clk_gen against a period-level reference model
`timescale 1ns/1ps
module tb_prog_clk_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] period_in = 8'd0;
  logic       load_valid = 1'b0;
`ifdef GLITCH_INJECT_EN
  logic       glitch_req = 1'b0;
`endif
  logic       load_ack, gen_clk, cycle_tick, pending, running;
  logic [7:0] period_cur;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b1;

  // reference model state: position inside the current period and the period in force
  bit m_on, m_drain, m_pend, m_gen, m_tick, m_ack;
  int m_pos, m_per, m_hold;

  prog_clk_gen #(.WIDTH(8), .DEFAULT_PERIOD(150)) dut (
    .main_clock (clk),
    .main_reset (rst_n),
    .enable     (enable),
    .period_in  (period_in),
    .load_valid (load_valid),
`ifdef GLITCH_INJECT_EN
    .glitch_req (glitch_req),
`endif
    .load_ack   (load_ack),
    .gen_clk    (gen_clk),
    .cycle_tick (cycle_tick),
    .period_cur (period_cur),
    .pending    (pending),
    .running    (running)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_on = 0; m_drain = 0; m_pend = 0; m_gen = 0; m_tick = 0; m_ack = 0;
    m_pos = 0; m_per = 150; m_hold = 150;
  endtask

  // one main_clock edge: loads move at period boundaries, gen_clk is high for the first P - P/2 cycles
  task automatic model_edge(input bit en, input bit lv, input int pin);
    bit bnd, cap, app;
    bnd = m_on && (m_pos == m_per - 1);
    cap = lv && !m_pend;
    app = m_pend && (!m_on || bnd);
    if (app) begin m_per = m_hold; m_pend = 0; end
    if (cap) begin m_hold = (pin < 2) ? 2 : pin; m_pend = 1; end
    m_ack = cap;
    if (!m_on) begin
      m_on = en; m_tick = en; m_pos = 0; m_drain = 0;
    end else if (bnd) begin
      if (m_drain && !en) begin m_on = 0; m_tick = 0; end
      else m_tick = 1;
      m_pos = 0; m_drain = !en;
    end else begin
      m_pos++; m_tick = 0; m_drain = !en;
    end
    m_gen = m_on && (m_pos < m_per - m_per / 2);
  endtask

  // cycle-by-cycle comparison against the model, sampled 1ns after the edge
  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else model_edge(enable, load_valid, int'(period_in));
    #1;
    if (chk_en) begin
      check_eq("gen_clk", gen_clk, m_gen);
      check_eq("cycle_tick", cycle_tick, m_tick);
      check_eq("load_ack", load_ack, m_ack);
      check_eq("pending", pending, m_pend);
      check_eq("period_cur", period_cur, m_per);
      check_eq("running", running, m_on);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tick();
    bit ok;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (cycle_tick) begin ok = 1; break; end
    end
    if (!ok) check_eq("tick_timeout", 0, 1);
  endtask

  // measures the period that starts at the next tick; returns at the tick that ends it
  task automatic measure(output int per, output int hi);
    per = 0; hi = 0;
    wait_tick();
    do begin
      if (gen_clk) hi++;
      per++;
      @(negedge clk);
    end while (!cycle_tick && per < 400);
  endtask

  task automatic do_load(input int p, input bit keep);
    bit ok;
    ok = 0;
    load_valid = 1; period_in = 8'(p);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (load_ack) begin ok = 1; break; end
    end
    if (!ok) check_eq("ack_timeout", 0, 1);
    load_valid = keep;
  endtask

  task automatic check_period(input string tag, input int p);
    int per, hi;
    measure(per, hi);
    check_eq({tag, "_per"}, per, p);
    check_eq({tag, "_hi"}, hi, p - p / 2);
  endtask

  function automatic logic [7:0] rnd_period();
    if ($urandom_range(0, 9) == 0) return 8'($urandom_range(0, 255));
    return 8'($urandom_range(0, 24));
  endfunction

  initial begin
    int n;
    cyc(2);
    check_eq("rst_gen_clk", gen_clk, 0);
    check_eq("rst_running", running, 0);
    check_eq("rst_pending", pending, 0);
    check_eq("rst_period_cur", period_cur, 150);

    rst_n = 1; enable = 1;
    check_period("default", 150);
    check_eq("default_cur", period_cur, 150);

    // load 7 at cnt=40
    cyc(40);
    load_valid = 1; period_in = 8'd7;
    cyc(1);
    check_eq("ack7", load_ack, 1);
    check_eq("pend7", pending, 1);
    load_valid = 0;
    check_period("p7a", 7);
    check_eq("pend7_clr", pending, 0);
    check_period("p7b", 7);

    // second request while pending waits for the first apply
    do_load(9, 1);
    do_load(20, 0);
    check_eq("second_cap_cur", period_cur, 9);
    check_eq("second_cap_pend", pending, 1);
    check_period("p20", 20);
    check_eq("p20_cur", period_cur, 20);

    // clamp and top-of-range
    do_load(0, 0);
    check_period("p0", 2);
    check_eq("p0_cur", period_cur, 2);
    do_load(1, 0);
    check_period("p1", 2);
    do_load(255, 0);
    check_period("p255", 255);

    // drain without truncation
    do_load(150, 0);
    check_period("p150", 150);
    cyc(10);
    enable = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (running && n < 400);
    check_eq("drain_len", n, 140);
    check_eq("drain_gen", gen_clk, 0);

    // re-enable during drain continues the waveform
    enable = 1;
    wait_tick();
    cyc(10);
    enable = 0;
    cyc(40);
    enable = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!cycle_tick && n < 400);
    check_eq("redrain_len", n, 100);
    check_period("after_redrain", 150);

    // reset mid high phase with a pending load
    cyc(5);
    load_valid = 1; period_in = 8'd40;
    cyc(1);
    load_valid = 0;
    check_eq("rst_pre_pend", pending, 1);
    #2 rst_n = 0;
    #1;
    check_eq("rst_mid_gen", gen_clk, 0);
    check_eq("rst_mid_pend", pending, 0);
    check_eq("rst_mid_cur", period_cur, 150);
    cyc(2);
    rst_n = 1;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!rst_n) rst_n = 1;
      else if ($urandom_range(0, 799) == 0) rst_n = 0;
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      if (load_valid) begin
        if (load_ack) begin
          if ($urandom_range(0, 3) == 0) period_in = rnd_period();
          else load_valid = 0;
        end
      end else if ($urandom_range(0, 29) == 0) begin
        load_valid = 1;
        period_in = rnd_period();
      end
    end
    load_valid = 0;

`ifdef GLITCH_INJECT_EN
    chk_en = 0;
    rst_n = 0;
    cyc(2);
    rst_n = 1; enable = 1;
    check_period("gl_pre", 150);
    cyc(20);
    glitch_req = 1;
    cyc(1);
    glitch_req = 0;
    check_period("gl_short", 2);
    check_period("gl_post", 150);
    check_eq("gl_cur", period_cur, 150);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_clk_gen.md
Name: prog_clk_gen

Overview:
- Programmable test-clock source that drives the clock monitor's measured input: the stimulus end of the period-check path.
- Divides main_clock into gen_clk with a runtime-programmable period P, counted in main_clock cycles.
- New periods are accepted through a valid/ack load handshake and are applied only at period boundaries, so gen_clk never glitches.
- Used to sweep gen_clk across the monitor's PSI_MIN/PSI_MAX/FRO_MIN limits in bench and lab setups.

Parameters:
- WIDTH, 8, width of period values and counter.
- DEFAULT_PERIOD, 150, period loaded at reset (main_clock cycles).

Ports:
- main_clock  input  1  sole clock; all logic on its rising edge.
- main_reset  input  1  asynchronous, active-low reset.
- enable  input  1  run request for gen_clk.
- period_in  input  WIDTH  requested period P in main_clock cycles.
- load_valid  input  1  period_in is valid; hold until load_ack.
- load_ack  output  1  one-cycle pulse: period_in captured.
- gen_clk  output  1  generated clock, registered.
- cycle_tick  output  1  one-cycle pulse coincident with each gen_clk rising edge.
- period_cur  output  WIDTH  period currently being generated.
- pending  output  1  a captured period is waiting for the next boundary.
- running  output  1  FSM in RUN or DRAIN.

Behaviour:
- Reset (main_reset=0, asynchronous): state IDLE, cnt=0, gen_clk=0, cycle_tick=0, load_ack=0, pending=0, running=0, period_cur=DEFAULT_PERIOD.
- Period clamp: captured values 0 and 1 are stored as 2. Valid range is 2..2^WIDTH-1.
- Waveform:
  - High phase H = P - floor(P/2). Low phase L = floor(P/2). Odd P gives the extra cycle to the high phase.
  - gen_clk = 1 while cnt < H, else 0.
  - cnt runs 0..P-1 and wraps to 0. The wrap is the period boundary.
- cycle_tick: asserted in the cycle in which gen_clk rises (cnt becomes 0 in RUN). 0 otherwise.
- Load handshake:
  - Capture condition: load_valid=1 and pending=0 at a rising edge. That edge stores period_in in the hold register and sets pending.
  - load_ack is high for exactly the cycle after the capture edge.
  - When pending=1, load_valid is ignored (no ack). The requester keeps load_valid high until it sees load_ack.
  - Holding load_valid high after an ack starts a new capture as soon as pending clears.
- Apply:
  - In IDLE: the pending value moves to period_cur on the next edge, and pending clears.
  - In RUN/DRAIN: the pending value moves to period_cur on the wrap edge, and the new period takes effect from cnt=0.
  - A capture on the same edge as a wrap is applied at the following wrap, never the current one.
- FSM:
  - IDLE: cnt=0, gen_clk=0. enable=1 -> RUN at the next edge, with cnt=0, gen_clk=1, cycle_tick=1 (one-edge latency).
  - RUN: count and wrap. enable=0 -> DRAIN.
  - DRAIN: finish the current period without truncation. At the wrap edge go to IDLE; gen_clk stays 0 and there is no cycle_tick.
  - DRAIN with enable back to 1 before the wrap: return to RUN, with no gap or extra edge.
- running=1 in RUN and DRAIN.
- Reset mid-period: immediate return to reset values. The pending capture is discarded.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: GLITCH_INJECT_EN.
- Defined:
  - Adds input glitch_req (1 bit).
  - A pulse in RUN arms a one-shot. The next period after the wrap is forced to P=2 (1 high, 1 low), then period_cur resumes.
  - A pending load still applies at the wrap after the glitch period.
  - The request is ignored in IDLE/DRAIN.
  - Purpose: provoke the monitor FAIL.
- Undefined: no glitch_req port, no one-shot logic. Behaviour is identical to the defined build with glitch_req tied 0.

Test Plan:
- Reset release, enable=1 -> gen_clk period 150 cycles (75 high/75 low); cycle_tick once per 150 cycles; period_cur=150.
- In RUN at cnt=40, load period_in=7 -> load_ack 1 cycle later; pending=1 until the wrap; then 4 high/3 low repeating; pending=0.
- Second load_valid (period_in=20) while pending -> no ack until the first apply; captured the cycle after pending clears; applied at the next wrap.
- period_in=0 and period_in=1 -> period_cur=2; gen_clk toggles every cycle.
- enable dropped at cnt=10 of P=150 -> 140 more cycles complete, then gen_clk=0, running=0. Re-assert enable during DRAIN -> continuous waveform, no extra tick.
- main_reset low mid-high-phase with pending=1 -> gen_clk=0 immediately; period_cur=150; pending=0. With GLITCH_INJECT_EN: glitch_req in RUN at P=150 -> exactly one 2-cycle period, then 150 again.
